// File: rtl/pg_pkg.sv
// Shared definitions for the packetgen egress adapter: sizing helpers,
// default-configuration geometry and the admission FSM encoding.
package pg_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    localparam int DEF_S_DATA_WIDTH = 512;
    localparam int DEF_M_DATA_WIDTH = 64;
    localparam int RATIO            = DEF_S_DATA_WIDTH / DEF_M_DATA_WIDTH;
    localparam int M_KEEP_WIDTH     = DEF_M_DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

endpackage

// File: rtl/pg_egress_serializer.sv
// Splits one buffered wide entry into narrow words, skipping empty words and
// holding the presented word while the downstream stalls.
module pg_egress_serializer
    import pg_pkg::*;
#(
    parameter int S_DATA_WIDTH = 512,
    parameter int M_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [S_DATA_WIDTH-1:0]   entry_data,
    input  logic [S_DATA_WIDTH/8-1:0] entry_keep,
    input  logic                      entry_last,
    output logic                      ready,
    output logic [M_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      tx_frame_done
);

    localparam int WORD_COUNT = S_DATA_WIDTH / M_DATA_WIDTH;
    localparam int MKW        = M_DATA_WIDTH / 8;
    localparam int IDX_W      = (WORD_COUNT > 1) ? clog2(WORD_COUNT) : 1;

    logic                    valid_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [IDX_W-1:0]        last_idx;
    logic [M_DATA_WIDTH-1:0] word_data [WORD_COUNT];
    logic [MKW-1:0]          word_keep [WORD_COUNT];
    logic [WORD_COUNT-1:0]   word_nz;
    logic                    at_last;
    logic                    handshake;
    logic                    done;

    generate
        for (genvar gi = 0; gi < WORD_COUNT; gi++) begin : g_word
            assign word_data[gi] = entry_data[gi*M_DATA_WIDTH +: M_DATA_WIDTH];
            assign word_keep[gi] = entry_keep[gi*MKW +: MKW];
            assign word_nz[gi]   = |entry_keep[gi*MKW +: MKW];
        end
    endgenerate

    // tkeep is contiguous, so everything above the highest non-empty word is skipped
    always_comb begin
        last_idx = '0;
        for (int k = 0; k < WORD_COUNT; k++) begin
            if (word_nz[k]) begin
                last_idx = IDX_W'(k);
            end
        end
    end

    assign at_last   = (idx_reg == last_idx);
    assign handshake = valid_reg && m_axis_tready;
    assign done      = handshake && at_last;
    assign ready     = !valid_reg || done;

    // The entry itself is held by the buffer's read register; only the word index lives here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            idx_reg   <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            idx_reg   <= '0;
        end else if (done) begin
            valid_reg <= 1'b0;
        end else if (handshake) begin
            idx_reg <= idx_reg + IDX_W'(1);
        end
    end

    assign m_axis_tvalid = valid_reg;
    assign m_axis_tdata  = valid_reg ? word_data[idx_reg] : '0;
    assign m_axis_tkeep  = valid_reg ? word_keep[idx_reg] : '0;
    assign m_axis_tlast  = valid_reg && entry_last && at_last;
    assign tx_frame_done = done && entry_last;

endmodule

// File: rtl/packetgen_egress_adapter.sv
// Buffers packetgen's non-stallable wide stream, admits or drops whole frames
// by free space, and serializes stored entries onto a narrow ready/valid stream.
module packetgen_egress_adapter
    import pg_pkg::*;
#(
    parameter int S_DATA_WIDTH    = 512,
    parameter int M_DATA_WIDTH    = 64,
    parameter int DEPTH_BEATS     = 64,
    parameter int MAX_FRAME_BEATS = 4,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [S_DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic [M_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [M_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [CNT_WIDTH-1:0]          stat_tx_frames,
    output logic [CNT_WIDTH-1:0]          stat_drop_frames,
    input  logic                          stat_clear,
    output logic [clog2(DEPTH_BEATS):0]   buf_level
);

    localparam int AW      = clog2(DEPTH_BEATS);
    localparam int PTR_W   = AW + 1;
    localparam int SKW     = S_DATA_WIDTH / 8;
    localparam int ENTRY_W = S_DATA_WIDTH + SKW;

    logic [ENTRY_W-1:0]     mem [DEPTH_BEATS];
    logic [DEPTH_BEATS-1:0] last_reg;
    logic [ENTRY_W-1:0]     rd_entry_reg;
    logic                   rd_last_reg;
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [PTR_W-1:0]       level;
    logic [AW-1:0]          wr_idx;
    logic [AW-1:0]          rd_idx;
    logic [AW-1:0]          prev_idx;
    logic                   full;
    logic                   empty;
    logic                   space_ok;
    logic                   wr_en;
    logic                   rd_en;
    logic                   trunc;
    logic                   drop_inc;
    logic                   tx_inc;
    logic                   ser_ready;
    logic [1:0]             state_reg;
    logic [1:0]             state_next;
    logic                   sync_reg;
    logic                   sync_next;
    logic [CNT_WIDTH-1:0]   tx_cnt_reg;
    logic [CNT_WIDTH-1:0]   drop_cnt_reg;

    assign wr_idx   = wr_ptr_reg[AW-1:0];
    assign rd_idx   = rd_ptr_reg[AW-1:0];
    assign prev_idx = wr_idx - AW'(1);
    assign level    = wr_ptr_reg - rd_ptr_reg;
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);
    assign space_ok = (level <= PTR_W'(DEPTH_BEATS - MAX_FRAME_BEATS));
    assign rd_en    = !empty && ser_ready;

    // sync_reg stays low after reset until a tlast is seen, so a frame cut by reset is never resumed
    always_comb begin
        state_next = state_reg;
        sync_next  = sync_reg;
        wr_en      = 1'b0;
        trunc      = 1'b0;
        drop_inc   = 1'b0;
        if (s_axis_tvalid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (!sync_reg) begin
                        if (s_axis_tlast) sync_next = 1'b1;
                        else              state_next = ST_DROP;
                    end else if (space_ok) begin
                        wr_en = 1'b1;
                        if (!s_axis_tlast) state_next = ST_PASS;
                    end else begin
                        drop_inc = 1'b1;
                        if (!s_axis_tlast) state_next = ST_DROP;
                    end
                end
                ST_PASS: begin
                    if (full) trunc = 1'b1;
                    else      wr_en = 1'b1;
                    if (s_axis_tlast) state_next = ST_IDLE;
                    else if (full)    state_next = ST_DROP;
                end
                ST_DROP: begin
                    if (s_axis_tlast) begin
                        state_next = ST_IDLE;
                        sync_next  = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            sync_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sync_reg  <= sync_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
    end

    // Data and keep share one RAM; tlast flags sit in flops so a truncated frame can be closed
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= {s_axis_tkeep, s_axis_tdata};
        if (rd_en) rd_entry_reg <= mem[rd_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_reg    <= '0;
            rd_last_reg <= 1'b0;
        end else begin
            if (wr_en) last_reg[wr_idx]   <= s_axis_tlast;
            if (trunc) last_reg[prev_idx] <= 1'b1;
            if (rd_en) rd_last_reg        <= last_reg[rd_idx];
        end
    end

    pg_egress_serializer #(
        .S_DATA_WIDTH (S_DATA_WIDTH),
        .M_DATA_WIDTH (M_DATA_WIDTH)
    ) u_serializer (
        .clk           (clk),
        .rst           (rst),
        .load          (rd_en),
        .entry_data    (rd_entry_reg[S_DATA_WIDTH-1:0]),
        .entry_keep    (rd_entry_reg[ENTRY_W-1:S_DATA_WIDTH]),
        .entry_last    (rd_last_reg),
        .ready         (ser_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .tx_frame_done (tx_inc)
    );

    // Saturating statistics; a clear overrides any increment in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt_reg   <= '0;
            drop_cnt_reg <= '0;
        end else if (stat_clear) begin
            tx_cnt_reg   <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (tx_inc && (tx_cnt_reg != '1))     tx_cnt_reg   <= tx_cnt_reg + CNT_WIDTH'(1);
            if (drop_inc && (drop_cnt_reg != '1)) drop_cnt_reg <= drop_cnt_reg + CNT_WIDTH'(1);
        end
    end

    assign stat_tx_frames   = tx_cnt_reg;
    assign stat_drop_frames = drop_cnt_reg;
    assign buf_level        = level;

endmodule

// File: tb/tb_packetgen_egress_adapter.sv
// Directed bench for packetgen_egress_adapter: 512->64 instance plus a
// 4-bit-counter instance on the same stimulus for saturation checks.
module tb_packetgen_egress_adapter;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } word_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [511:0] s_axis_tdata = '0;
    logic [63:0]  s_axis_tkeep = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic         m_axis_tready = 1'b0;
    logic         stat_clear = 1'b0;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic [31:0]  stat_tx_frames;
    logic [31:0]  stat_drop_frames;
    logic [6:0]   buf_level;
    logic [63:0]  sat_tdata;
    logic [7:0]   sat_tkeep;
    logic         sat_tvalid;
    logic         sat_tlast;
    logic [3:0]   sat_tx_frames;
    logic [3:0]   sat_drop_frames;
    logic [6:0]   sat_level;

    int    checks = 0;
    int    errors = 0;
    int    tready_mode = 0;
    int    stall_viol = 0;
    word_t exp_q[$];
    word_t obs_q[$];
    logic  prev_stall = 1'b0;
    word_t prev_w;

    packetgen_egress_adapter #(
        .S_DATA_WIDTH(512), .M_DATA_WIDTH(64), .DEPTH_BEATS(64), .MAX_FRAME_BEATS(4), .CNT_WIDTH(32)
    ) u_dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .stat_tx_frames(stat_tx_frames), .stat_drop_frames(stat_drop_frames),
        .stat_clear(stat_clear), .buf_level(buf_level)
    );

    packetgen_egress_adapter #(
        .S_DATA_WIDTH(512), .M_DATA_WIDTH(64), .DEPTH_BEATS(64), .MAX_FRAME_BEATS(4), .CNT_WIDTH(4)
    ) u_sat (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(sat_tdata), .m_axis_tkeep(sat_tkeep),
        .m_axis_tvalid(sat_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(sat_tlast),
        .stat_tx_frames(sat_tx_frames), .stat_drop_frames(sat_drop_frames),
        .stat_clear(stat_clear), .buf_level(sat_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        case (tready_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Records every handshaked word and counts any change while stalled
    always @(negedge clk) begin
        word_t cur;
        cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_axis_tvalid || cur !== prev_w)) stall_viol++;
            if (m_axis_tvalid && m_axis_tready) obs_q.push_back(cur);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_w = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
    endtask

    task automatic drive_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Sends bytes seed, seed+1, ... and, if admitted, queues the expected 8-byte words
    task automatic send_frame(input int nbytes, input int seed, input bit admit);
        int nbeats;
        int nwords;
        logic [511:0] d;
        logic [63:0]  k;
        word_t w;
        nbeats = (nbytes + 63) / 64;
        nwords = (nbytes + 7) / 8;
        for (int b = 0; b < nbeats; b++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 64; j++) begin
                if (b*64 + j < nbytes) begin
                    d[j*8 +: 8] = 8'(seed + b*64 + j);
                    k[j] = 1'b1;
                end
            end
            drive_beat(d, k, b == nbeats - 1);
        end
        if (admit) begin
            for (int wi = 0; wi < nwords; wi++) begin
                w = '0;
                for (int j = 0; j < 8; j++) begin
                    if (wi*8 + j < nbytes) begin
                        w.d[j*8 +: 8] = 8'(seed + wi*8 + j);
                        w.k[j] = 1'b1;
                    end
                end
                w.l = (wi == nwords - 1);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic wait_words(input int n, input int max_cycles, output bit ok);
        for (int c = 0; c < max_cycles; c++) begin
            if (obs_q.size() >= n) break;
            tick();
        end
        ok = (obs_q.size() >= n);
        repeat (5) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 64'h0) begin errors++; $display("FAIL rst_tdata got %h want 0", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== 8'h0) begin errors++; $display("FAIL rst_tkeep got %h want 0", m_axis_tkeep); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", m_axis_tlast); end
        checks++; if (stat_tx_frames !== 32'd0) begin errors++; $display("FAIL rst_tx got %0d want 0", stat_tx_frames); end
        checks++; if (stat_drop_frames !== 32'd0) begin errors++; $display("FAIL rst_drop got %0d want 0", stat_drop_frames); end
        checks++; if (buf_level !== 7'd0) begin errors++; $display("FAIL rst_level got %0d want 0", buf_level); end
        rst = 1'b1;
        tready_mode = 1;
        tick();
        obs_q.delete();
        // The first frame after reset is only a resync point and must not appear
        send_frame(24, 8'h55, 1'b0);
        repeat (10) tick();
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL rst_resync_words got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        tready_mode = 1;
        pulse_clear();
        obs_q.delete(); exp_q.delete();
        for (int f = 0; f < 8; f++) send_frame(24, f*16, 1'b1);
        wait_words(24, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got %0d words want 24", obs_q.size()); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_word[%0d] got d=%h k=%h l=%b want d=%h k=%h l=%b", i, obs_q[i].d, obs_q[i].k, obs_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
        checks++; if (stat_tx_frames !== 32'd8) begin errors++; $display("FAIL b2b_tx got %0d want 8", stat_tx_frames); end
        checks++; if (stat_drop_frames !== 32'd0) begin errors++; $display("FAIL b2b_drop got %0d want 0", stat_drop_frames); end
    endtask

    task automatic test_skip_words();
        bit ok;
        tready_mode = 1;
        pulse_clear();
        obs_q.delete(); exp_q.delete();
        send_frame(100, 8'hA0, 1'b1);
        wait_words(13, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL skip_timeout got %0d words want 13", obs_q.size()); end
        checks++; if (obs_q.size() !== 13) begin errors++; $display("FAIL skip_count got %0d want 13", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL skip_word[%0d] got d=%h k=%h l=%b want d=%h k=%h l=%b", i, obs_q[i].d, obs_q[i].k, obs_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
        checks++; if (stat_tx_frames !== 32'd1) begin errors++; $display("FAIL skip_tx got %0d want 1", stat_tx_frames); end
    endtask

    task automatic test_admission();
        bit ok;
        int lasts;
        tready_mode = 0;
        tick();
        pulse_clear();
        obs_q.delete(); exp_q.delete();
        for (int f = 0; f < 40; f++) send_frame(128, f*3, f < 31);
        repeat (100) tick();
        checks++; if (buf_level !== 7'd61) begin errors++; $display("FAIL adm_level got %0d want 61", buf_level); end
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL adm_stalled_valid got %b want 1", m_axis_tvalid); end
        checks++; if (stat_drop_frames !== 32'd9) begin errors++; $display("FAIL adm_drop got %0d want 9", stat_drop_frames); end
        tready_mode = 1;
        wait_words(496, 3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL adm_timeout got %0d words want 496", obs_q.size()); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL adm_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        lasts = 0;
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i].l) lasts++;
        checks++; if (lasts !== 31) begin errors++; $display("FAIL adm_frames_out got %0d want 31", lasts); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL adm_word[%0d] got d=%h k=%h l=%b want d=%h k=%h l=%b", i, obs_q[i].d, obs_q[i].k, obs_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
        checks++; if (stat_tx_frames !== 32'd31) begin errors++; $display("FAIL adm_tx got %0d want 31", stat_tx_frames); end
    endtask

    task automatic test_random_ready();
        bit ok;
        int sizes[10] = '{8, 64, 65, 100, 130, 192, 1, 57, 120, 180};
        tready_mode = 2;
        pulse_clear();
        obs_q.delete(); exp_q.delete();
        stall_viol = 0;
        for (int f = 0; f < 10; f++) send_frame(sizes[f], f*31, 1'b1);
        wait_words(119, 3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rnd_timeout got %0d words want 119", obs_q.size()); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rnd_word[%0d] got d=%h k=%h l=%b want d=%h k=%h l=%b", i, obs_q[i].d, obs_q[i].k, obs_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL rnd_stall_stable got %0d changes want 0", stall_viol); end
        checks++; if (stat_tx_frames !== 32'd10) begin errors++; $display("FAIL rnd_tx got %0d want 10", stat_tx_frames); end
        tready_mode = 1;
        repeat (3) tick();
    endtask

    task automatic test_reset_midframe();
        bit ok;
        logic [511:0] d;
        tready_mode = 1;
        d = {64{8'h3C}};
        drive_beat(d, '1, 1'b0);
        drive_beat(d, '1, 1'b0);
        rst = 1'b0;
        #2;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mrst_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 64'h0) begin errors++; $display("FAIL mrst_tdata got %h want 0", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== 8'h0) begin errors++; $display("FAIL mrst_tkeep got %h want 0", m_axis_tkeep); end
        checks++; if (stat_tx_frames !== 32'd0) begin errors++; $display("FAIL mrst_tx got %0d want 0", stat_tx_frames); end
        checks++; if (buf_level !== 7'd0) begin errors++; $display("FAIL mrst_level got %0d want 0", buf_level); end
        tick();
        tick();
        rst = 1'b1;
        obs_q.delete(); exp_q.delete();
        drive_beat(d, '1, 1'b1);
        send_frame(72, 8'h10, 1'b1);
        wait_words(9, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mrst_timeout got %0d words want 9", obs_q.size()); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL mrst_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mrst_word[%0d] got d=%h k=%h l=%b want d=%h k=%h l=%b", i, obs_q[i].d, obs_q[i].k, obs_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
        checks++; if (stat_tx_frames !== 32'd1) begin errors++; $display("FAIL mrst_tx got %0d want 1", stat_tx_frames); end
    endtask

    task automatic test_saturation_clear();
        bit ok;
        tready_mode = 0;
        repeat (3) tick();
        pulse_clear();
        obs_q.delete(); exp_q.delete();
        for (int f = 0; f < 80; f++) send_frame(8, f, 1'b0);
        repeat (5) tick();
        checks++; if (stat_drop_frames !== 32'd18) begin errors++; $display("FAIL sat_drop32 got %0d want 18", stat_drop_frames); end
        checks++; if (sat_drop_frames !== 4'hF) begin errors++; $display("FAIL sat_drop4 got %h want f", sat_drop_frames); end
        checks++; if (buf_level !== 7'd61) begin errors++; $display("FAIL sat_level got %0d want 61", buf_level); end
        // Release the stall in the same cycle as the clear so a tlast handshake coincides with it
        stat_clear = 1'b1;
        tready_mode = 1;
        tick();
        stat_clear = 1'b0;
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL clr_handshake got %0d words want 1", obs_q.size()); end
        checks++; if (stat_tx_frames !== 32'd0) begin errors++; $display("FAIL clr_tx32 got %0d want 0", stat_tx_frames); end
        checks++; if (sat_tx_frames !== 4'h0) begin errors++; $display("FAIL clr_tx4 got %h want 0", sat_tx_frames); end
        checks++; if (stat_drop_frames !== 32'd0) begin errors++; $display("FAIL clr_drop32 got %0d want 0", stat_drop_frames); end
        checks++; if (sat_drop_frames !== 4'h0) begin errors++; $display("FAIL clr_drop4 got %h want 0", sat_drop_frames); end
        wait_words(62, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_timeout got %0d words want 62", obs_q.size()); end
        checks++; if (stat_tx_frames !== 32'd61) begin errors++; $display("FAIL sat_tx32 got %0d want 61", stat_tx_frames); end
        checks++; if (sat_tx_frames !== 4'hF) begin errors++; $display("FAIL sat_tx4 got %h want f", sat_tx_frames); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_skip_words();
        test_admission();
        test_random_ready();
        test_reset_midframe();
        test_saturation_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
